main_memory_responder: RTL and testbench

- Main-memory side of the cache refill / write-through interface.
- Accepts one request at a time from the cache controller over a valid/ready handshake.
- Read request: after a fixed latency, returns an aligned 128-bit line in the format the cache data array writes on its main-memory port.
- Write request: after the same latency, commits one 32-bit word.

---
 rtl/main_mem_pkg.sv | 18 +
 rtl/main_mem_array.sv | 37 +++
 rtl/main_memory_responder.sv | 123 ++++++++++++
 tb/tb_main_memory_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared definitions for the main-memory responder slice.
//   state_t        : responder FSM states
//   WORDS_PER_LINE : words per cache line
//   OFFSET_W       : word-offset bits inside a line
//   CNT_W          : latency counter width (covers LATENCY up to 255)
package main_mem_pkg;

  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFFSET_W       = 2;
  localparam int unsigned CNT_W          = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/main_mem_array.sv
// Word-addressed storage behind the main-memory responder.
// One synchronous write port plus a combinational read of a whole aligned
// line. The array is not reset.
//   clk        : write clock
//   we         : write enable
//   waddr      : word address of the write
//   wdata      : write data
//   line_addr  : line index (word address without the offset bits)
//   line_rdata : the addressed line, word k in bits [k*RISC_data +: RISC_data]
module main_mem_array
  import main_mem_pkg::*;
#(
  parameter int unsigned RISC_data = 32,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [ADDR_W-1:0]                   waddr,
  input  logic [RISC_data-1:0]                wdata,
  input  logic [ADDR_W-OFFSET_W-1:0]          line_addr,
  output logic [WORDS_PER_LINE*RISC_data-1:0] line_rdata
);

  logic [RISC_data-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    line_rdata = '0;
    for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
      line_rdata[k*RISC_data +: RISC_data] = mem[{line_addr, OFFSET_W'(k)}];
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory side of the cache refill / write-through interface.
// Accepts one request at a time; after LATENCY cycles a read returns an
// aligned 128-bit line (line_valid pulse) or a write commits one word
// (wr_done pulse). Throughput is one request per LATENCY+2 cycles.
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/req_ready: request handshake
//   req_write          : 1 = word write, 0 = line read
//   req_addr           : word address (reads ignore the two offset bits)
//   req_wdata          : write data
//   line_valid         : one-cycle read-response pulse
//   line_data          : last read line, held until the next read completes
//   wr_done            : one-cycle write-commit pulse
// Optional: define MEM_STATS_EN to add saturating rd_count/wr_count outputs.
module main_memory_responder
  import main_mem_pkg::*;
#(
  parameter int unsigned RISC_data = 32,
  parameter int unsigned main_data = 128,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [RISC_data-1:0] req_wdata,
  output logic                 line_valid,
  output logic [main_data-1:0] line_data,
`ifdef MEM_STATS_EN
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count,
`endif
  output logic                 wr_done
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 cap_write_q;
  logic [ADDR_W-1:0]    cap_addr_q;
  logic [RISC_data-1:0] cap_wdata_q;
  logic [main_data-1:0] arr_line;
  logic                 complete;
  logic                 mem_we;

  // The completing edge is the last WAIT cycle; the array write and the
  // line capture both happen on it so RESP sees committed results.
  assign complete = (state_q == WAIT) && (cnt_q == '0);
  assign mem_we   = complete && cap_write_q;

  main_mem_array #(
    .RISC_data (RISC_data),
    .ADDR_W    (ADDR_W)
  ) u_array (
    .clk        (clk),
    .we         (mem_we),
    .waddr      (cap_addr_q),
    .wdata      (cap_wdata_q),
    .line_addr  (cap_addr_q[ADDR_W-1:OFFSET_W]),
    .line_rdata (arr_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    line_valid = 1'b0;
    wr_done    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        line_valid = !cap_write_q;
        wr_done    = cap_write_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cap_write_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      line_data   <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        cnt_q       <= CNT_W'(LATENCY - 1);
        cap_write_q <= req_write;
        cap_addr_q  <= req_addr;
        cap_wdata_q <= req_wdata;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (complete && !cap_write_q) line_data <= arr_line;
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (line_valid && rd_count != '1) rd_count <= rd_count + 1'b1;
      if (wr_done    && wr_count != '1) wr_count <= wr_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Randomized scoreboard bench for main_memory_responder (LATENCY=4 instance)
// plus a directed timing check of a LATENCY=1 instance.
module tb_main_memory_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0, req_write = 1'b0;
  logic [9:0]   req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic         req_ready, line_valid, wr_done;
  logic [127:0] line_data;

  logic         r1_valid = 1'b0, r1_write = 1'b0;
  logic [9:0]   r1_addr = '0;
  logic [31:0]  r1_wdata = '0;
  logic         r1_ready, r1_line_valid, r1_wr_done;
  logic [127:0] r1_line_data;
`ifdef MEM_STATS_EN
  logic [15:0]  rd_count, wr_count, r1_rd_count, r1_wr_count;
`endif

  main_memory_responder #(.RISC_data(32), .main_data(128), .ADDR_W(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .line_valid(line_valid), .line_data(line_data),
`ifdef MEM_STATS_EN
    .rd_count(rd_count), .wr_count(wr_count),
`endif
    .wr_done(wr_done)
  );

  main_memory_responder #(.RISC_data(32), .main_data(128), .ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(r1_valid), .req_ready(r1_ready),
    .req_write(r1_write), .req_addr(r1_addr), .req_wdata(r1_wdata),
    .line_valid(r1_line_valid), .line_data(r1_line_data),
`ifdef MEM_STATS_EN
    .rd_count(r1_rd_count), .wr_count(r1_wr_count),
`endif
    .wr_done(r1_wr_done)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word memory, last returned line, outstanding requests.
  typedef struct {
    bit           wr;
    logic [9:0]   addr;
    logic [31:0]  data;
    logic [127:0] line;
    int           due;
  } txn_t;

  logic [31:0]  model_mem [1024];
  logic [127:0] model_line = '0;
  txn_t         sb[$];
  int           cyc = 0;
  int           last_acc = -1000;
  int           rd_seen = 0, wr_seen = 0;
  txn_t         mon_t;
  logic [9:0]   mon_base;

  always @(posedge clk) cyc++;

  // Monitor: samples at the falling edge, between active edges.
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", req_ready, cyc >= last_acc + LAT + 1);
      if (line_valid || wr_done) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_response: got line_valid=%b wr_done=%b required none", line_valid, wr_done);
        end else begin
          mon_t = sb.pop_front();
          check("resp_cycle", cyc, mon_t.due);
          check("resp_kind", {line_valid, wr_done}, mon_t.wr ? 2'b01 : 2'b10);
          if (mon_t.wr) begin
            model_mem[mon_t.addr] = mon_t.data;
            check("line_hold", line_data, model_line);
            wr_seen++;
          end else begin
            check("line_data", line_data, mon_t.line);
            model_line = mon_t.line;
            rd_seen++;
          end
        end
      end
      if (req_valid && req_ready) begin
        mon_base   = {req_addr[9:2], 2'b00};
        mon_t.wr   = req_write;
        mon_t.addr = req_addr;
        mon_t.data = req_wdata;
        mon_t.line = {model_mem[mon_base + 10'd3], model_mem[mon_base + 10'd2],
                      model_mem[mon_base + 10'd1], model_mem[mon_base]};
        mon_t.due  = cyc + 1 + LAT;
        sb.push_back(mon_t);
        last_acc   = cyc + 1;
      end
    end
  end

  task automatic send(input bit w, input logic [9:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got req_ready=0 for 50 cycles required 1");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL response_timeout: got %0d outstanding required 0", sb.size());
      sb.delete();
    end
    @(negedge clk); #1;
  endtask

  logic [31:0] old5;

  initial begin
    #12;
    check("rst_ready", req_ready, 1'b1);
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_wr_done", wr_done, 1'b0);
    check("rst_line_data", line_data, '0);
    #11 rst_n = 1'b1;

    for (int a = 0; a < 64; a++) begin
      send(1'b1, 10'(a), (a >= 8 && a <= 11) ? 32'((a - 7) * 11) : $urandom);
      drain();
    end

    send(1'b0, 10'd10, 32'h0);
    drain();
    check("read_line8", line_data, {32'd44, 32'd33, 32'd22, 32'd11});

    send(1'b1, 10'd13, 32'hDEADBEEF);
    drain();
    check("write_keeps_line", line_data, {32'd44, 32'd33, 32'd22, 32'd11});
    send(1'b0, 10'd12, 32'h0);
    drain();
    check("raw_word1", line_data[63:32], 32'hDEADBEEF);

    // Abort a write mid-WAIT with reset; it must not commit.
    old5 = model_mem[5];
    send(1'b1, 10'd5, 32'hCAFE0005);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", req_ready, 1'b1);
    check("abort_line_valid", line_valid, 1'b0);
    check("abort_wr_done", wr_done, 1'b0);
    check("abort_line_data", line_data, '0);
    sb.delete();
    last_acc = -1000;
    model_line = '0;
    rd_seen = 0;
    wr_seen = 0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    send(1'b0, 10'd4, 32'h0);
    drain();
    check("abort_no_commit", line_data[63:32], old5);

    // Requests held continuously with changing fields; the monitor records
    // whatever is present on the accepting edge.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 10'($urandom_range(0, 63));
      req_wdata = $urandom;
    end
    req_valid = 1'b0;
    drain();

    // LATENCY=1 instance: write addr 1, then read line 0.
    @(posedge clk); #1;
    r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 10'd1; r1_wdata = 32'h12345678;
    @(posedge clk); #1;
    r1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    r1_valid = 1'b1; r1_write = 1'b0; r1_addr = 10'd0;
    @(posedge clk); #1;
    r1_valid = 1'b0;
    @(negedge clk);
    check("l1_e0_valid", r1_line_valid, 1'b0);
    check("l1_e0_ready", r1_ready, 1'b0);
    @(negedge clk);
    check("l1_e1_valid", r1_line_valid, 1'b1);
    check("l1_e1_ready", r1_ready, 1'b0);
    check("l1_e1_word1", r1_line_data[63:32], 32'h12345678);
    @(negedge clk);
    check("l1_e2_valid", r1_line_valid, 1'b0);
    check("l1_e2_ready", r1_ready, 1'b1);

`ifdef MEM_STATS_EN
    check("rd_count", rd_count, 16'(rd_seen));
    check("wr_count", wr_count, 16'(wr_seen));
    @(negedge clk);
    force dut.rd_count = 16'hFFFF;
    #1 release dut.rd_count;
    send(1'b0, 10'd0, 32'h0);
    drain();
    check("rd_count_sat", rd_count, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
